// File: rtl/ball_ctrl_pkg.sv
// Shared playfield geometry, FSM state encoding and a coordinate helper
// for the ball sequencer and its tick divider.
package ball_ctrl_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int BALL_SIZE = 2;
  localparam int PLAT_Y    = 112;
  localparam int PLATSIZE  = 20;
  localparam int PLATHALF  = PLATSIZE / 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_STEP  = 3'd2,
    ST_CHECK = 3'd3,
    ST_LOST  = 3'd4
  } state_t;

  // A position counter that stepped below zero wraps to a large value;
  // treat anything above 1000 as sitting on the left/top edge.
  function automatic logic [10:0] clip_underflow(input logic [9:0] v);
    return (v > 10'd1000) ? 11'd0 : {1'b0, v};
  endfunction

endpackage

// File: rtl/ball_tick_div.sv
// Loadable down-counter that paces ball steps.
// Optional feature macro: BALL_SPEEDUP_EN -- when defined, this block also
// owns the active divider and a 2-bit platform-hit counter; every fourth
// platform hit shortens the divider by TICK_DIV/8, floored at TICK_DIV/4.
module ball_tick_div
  import ball_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic restore,
  input  logic reload,
  input  logic dec,
  input  logic plat_hit,
  output logic zero
);

  localparam int CW = $clog2(TICK_DIV + 1);

  logic [CW-1:0] count;
  logic [CW-1:0] reload_val;

`ifdef BALL_SPEEDUP_EN
  localparam logic [CW-1:0] DIV_FULL = CW'(TICK_DIV);
  localparam logic [CW-1:0] DIV_STEP = CW'(TICK_DIV / 8);
  localparam logic [CW-1:0] DIV_MIN  = CW'(TICK_DIV / 4);

  logic [CW-1:0] div_q;
  logic [CW-1:0] div_d;
  logic [1:0]    hits_q;

  // Next divider: restored on launch, shortened on every fourth platform hit.
  always_comb begin
    div_d = div_q;
    if (restore) begin
      div_d = DIV_FULL;
    end else if (plat_hit && (hits_q == 2'd3)) begin
      div_d = (div_q < DIV_MIN + DIV_STEP) ? DIV_MIN : div_q - DIV_STEP;
    end
  end

  // Divider and hit-count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= DIV_FULL;
      hits_q <= 2'd0;
    end else begin
      div_q <= div_d;
      if (restore) begin
        hits_q <= 2'd0;
      end else if (plat_hit) begin
        hits_q <= hits_q + 2'd1;
      end
    end
  end

  assign reload_val = div_d - CW'(1);
`else
  logic unused_inputs;
  assign unused_inputs = &{1'b0, restore, plat_hit};
  assign reload_val    = CW'(TICK_DIV - 1);
`endif

  // Wait counter: reloads on request, otherwise counts down to zero and holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= CW'(TICK_DIV - 1);
    end else if (reload) begin
      count <= reload_val;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ball_ctrl.sv
// Ball sequencer: paces position steps, evaluates wall/platform/brick/floor
// collisions after each step and steers the ball direction bits.
// Optional feature macro: BALL_SPEEDUP_EN (handled inside ball_tick_div).
module ball_ctrl
  import ball_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       launch,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] platx,
  input  logic       brick_hit_v,
  input  logic       brick_hit_h,
  output logic       step_en,
  output logic       x_du,
  output logic       y_du,
  output logic       plat_col,
  output logic       pos_reset,
  output logic       ball_lost,
  output logic [2:0] state_o
);

  state_t state;
  state_t next_state;

  logic [10:0] x_w;
  logic [10:0] y_w;
  logic [10:0] platx_w;
  logic [10:0] x_l;
  logic [10:0] y_l;

  logic hit_l;
  logic hit_r;
  logic hit_t;
  logic hit_p;
  logic hit_f;

  logic x_du_d;
  logic y_du_d;
  logic cnt_zero;
  logic cnt_reload;
  logic cnt_dec;
  logic plat_hit;
  logic launch_go;

  assign x_w     = {1'b0, x};
  assign y_w     = {1'b0, y};
  assign platx_w = {1'b0, platx};
  assign x_l     = clip_underflow(x);
  assign y_l     = clip_underflow(y);

  ball_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk      (clk),
    .reset    (reset),
    .restore  (launch_go),
    .reload   (cnt_reload),
    .dec      (cnt_dec),
    .plat_hit (plat_hit),
    .zero     (cnt_zero)
  );

  // Collision tests on the freshly stepped position, all in 11 bits.
  always_comb begin
    hit_l = !x_du && (x_l <= 11'd1);
    hit_r = x_du && (x_w >= 11'(SCREEN_W - BALL_SIZE - 1));
    hit_t = !y_du && (y_l <= 11'd1);
    hit_p = y_du
         && (y_w + 11'(BALL_SIZE) >= 11'(PLAT_Y))
         && (y_w + 11'(BALL_SIZE) <= 11'(PLAT_Y + 1))
         && (x_w + 11'(BALL_SIZE) > platx_w)
         && (x_w < platx_w + 11'(PLATSIZE));
    hit_f = y_du && (y_w >= 11'(SCREEN_H - BALL_SIZE));
  end

  // Next state, counter control and direction updates.
  always_comb begin
    next_state = state;
    cnt_reload = 1'b0;
    cnt_dec    = 1'b0;
    plat_hit   = 1'b0;
    launch_go  = 1'b0;
    x_du_d     = x_du;
    y_du_d     = y_du;
    case (state)
      ST_IDLE, ST_LOST: begin
        if (launch) begin
          next_state = ST_WAIT;
          cnt_reload = 1'b1;
          launch_go  = 1'b1;
          x_du_d     = 1'b1;
          y_du_d     = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          next_state = ST_STEP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_STEP: begin
        next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (brick_hit_h) x_du_d = !x_du_d;
        if (brick_hit_v) y_du_d = !y_du_d;
        if (hit_l) x_du_d = 1'b1;
        if (hit_r) x_du_d = 1'b0;
        if (hit_t) y_du_d = 1'b1;
        if (hit_p) begin
          y_du_d   = 1'b0;
          plat_hit = 1'b1;
          x_du_d   = (x_w + 11'(BALL_SIZE / 2)) >= (platx_w + 11'(PLATHALF));
        end
        if (hit_f && !hit_p) begin
          next_state = ST_LOST;
        end else begin
          next_state = ST_WAIT;
          cnt_reload = 1'b1;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State, direction and registered (glitch-free) output strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      x_du      <= 1'b1;
      y_du      <= 1'b0;
      step_en   <= 1'b0;
      plat_col  <= 1'b0;
      pos_reset <= 1'b1;
      ball_lost <= 1'b0;
    end else begin
      state     <= next_state;
      x_du      <= x_du_d;
      y_du      <= y_du_d;
      step_en   <= (next_state == ST_STEP);
      plat_col  <= plat_hit;
      pos_reset <= (next_state == ST_IDLE) || (next_state == ST_LOST);
      ball_lost <= (next_state == ST_LOST);
    end
  end

  assign state_o = state;

endmodule
